sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_msg_schedule.sv | 80 ++++++++
 tb/tb_sha256_msg_schedule.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator.
// Accepts one padded 512-bit block, then streams the 64 schedule words W0..W63
// over a valid/ready channel. A 16-word sliding window holds W[t..t+15];
// every transfer shifts the window by one and appends the next expanded word.
module sha256_msg_schedule (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w_data,
   output logic [5:0]   w_idx,
   output logic         w_last
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [15:0][31:0] win;    // win[0] is the word currently offered downstream
   logic [5:0]        t;
   logic [31:0]       w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // Next schedule word W[t+16] from the current window; adds wrap mod 2^32.
   always_comb begin
      w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
   end

   // Control and window update: load on block accept, shift on word transfer.
   // Accept only happens in IDLE and transfer only in RUN, so they never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         t     <= 6'd0;
         win   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (blk_valid) begin
                  for (int i = 0; i < 16; i++)
                     win[i] <= blk_data[511-32*i -: 32];
                  t     <= 6'd0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (w_ready) begin
                  for (int i = 0; i < 15; i++)
                     win[i] <= win[i+1];
                  win[15] <= w_new;
                  if (t == 6'd63) begin
                     state <= IDLE;
                     t     <= 6'd0;
                  end else begin
                     t <= t + 6'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from registers, so they hold steady across stalls.
   assign blk_ready = (state == IDLE);
   assign w_valid   = (state == RUN);
   assign w_data    = win[0];
   assign w_idx     = t;
   assign w_last    = (state == RUN) && (t == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: driver pushes the reference schedule of each
// accepted block into a queue, a negedge monitor pops and compares transfers.
module tb_sha256_msg_schedule;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;

   sha256_msg_schedule dut (
      .clk(clk), .rst_n(rst_n),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_idx(w_idx), .w_last(w_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t   exp_q[$];
   int     nvec = 0;
   int     nerr = 0;
   int     kmode = 0;     // 1: "abc" block, 2: all-ones, 3: all-zero
   logic   rdy_rand = 1'b0;

   localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] ONES_BLK = {512{1'b1}};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (time %0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: textbook SHA-256 expansion over a flat 64-word array.
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic push_block(input logic [511:0] b);
      logic [31:0] w [64];
      exp_t e;
      for (int k = 0; k < 16; k++) w[k] = b[511-32*k -: 32];
      for (int k = 16; k < 64; k++)
         w[k] = (rotr(w[k-2], 17) ^ rotr(w[k-2], 19) ^ (w[k-2] >> 10))
              + w[k-7]
              + (rotr(w[k-15], 7) ^ rotr(w[k-15], 18) ^ (w[k-15] >> 3))
              + w[k-16];
      for (int k = 0; k < 64; k++) begin
         e.idx = 6'(k); e.data = w[k]; e.last = (k == 63);
         exp_q.push_back(e);
      end
   endtask

   function automatic logic [511:0] rnd_blk();
      logic [511:0] b;
      for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
      return b;
   endfunction

   // After an accept, W0 must be presented in the very next cycle.
   task automatic check_first_word();
      @(negedge clk);
      chk("first_word_latency", {w_valid, blk_ready, w_idx}, {1'b1, 1'b0, 6'd0});
   endtask

   // Offer one block; the expected words are queued at the accepting cycle.
   task automatic send_block(input logic [511:0] b);
      int n = 0;
      @(posedge clk); #1;
      blk_valid = 1'b1;
      blk_data  = b;
      @(negedge clk);
      while (!blk_ready && n < 1000) begin @(negedge clk); n++; end
      chk("accept_timeout", 64'(n < 1000), 64'd1);
      push_block(b);
      @(posedge clk); #1;
      blk_valid = 1'b0;
      blk_data  = rnd_blk();   // must be ignored from here on
      check_first_word();
   endtask

   // Two blocks with blk_valid held high throughout.
   task automatic send_b2b(input logic [511:0] a, input logic [511:0] b);
      int n = 0;
      @(posedge clk); #1;
      blk_valid = 1'b1;
      blk_data  = a;
      @(negedge clk);
      while (!blk_ready && n < 1000) begin @(negedge clk); n++; end
      push_block(a);
      @(posedge clk); #1;
      blk_data = b;
      n = 0;
      @(negedge clk);
      while (!blk_ready && n < 1000) begin @(negedge clk); n++; end
      chk("b2b_accept_timeout", 64'(n < 1000), 64'd1);
      push_block(b);
      @(posedge clk); #1;
      blk_valid = 1'b0;
      blk_data  = rnd_blk();
      check_first_word();
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || w_valid) && n < 3000) begin @(negedge clk); n++; end
      chk("drain_timeout", 64'(n < 3000), 64'd1);
   endtask

   // Downstream ready: always high or ~50% random (also toggles in IDLE).
   always @(posedge clk) begin
      #1;
      w_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: handshake scoreboard, stall stability, idle-after-last, known words.
   logic        stall_pend = 1'b0;
   logic        last_hs = 1'b0;
   logic [38:0] stall_snap;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         stall_pend = 1'b0;
         last_hs    = 1'b0;
      end else begin
         chk("ready_vs_run", 64'(blk_ready), 64'(!w_valid));
         if (last_hs) chk("idle_after_w63", {w_valid, blk_ready}, 2'b01);
         if (stall_pend) chk("stall_hold", {w_data, w_idx, w_last}, stall_snap);
         stall_pend = w_valid && !w_ready;
         stall_snap = {w_data, w_idx, w_last};
         last_hs    = w_valid && w_ready && w_last;
         if (w_valid && w_ready) begin
            if (exp_q.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL unexpected_word: got idx %0d data %h, expected no word", w_idx, w_data);
            end else begin
               e = exp_q.pop_front();
               chk("w_idx", w_idx, e.idx);
               chk("w_data", w_data, e.data);
               chk("w_last", w_last, e.last);
               if (kmode == 1) begin
                  if (w_idx == 0)  chk("abc_w0",  w_data, 32'h61626380);
                  if (w_idx == 15) chk("abc_w15", w_data, 32'h00000018);
                  if (w_idx == 16) chk("abc_w16", w_data, 32'h61626380);
                  if (w_idx == 17) chk("abc_w17", w_data, 32'h000F0000);
               end else if (kmode == 2) begin
                  if (w_idx < 16)  chk("ones_w0_15", w_data, 32'hFFFFFFFF);
                  if (w_idx == 16) chk("ones_w16", w_data, 32'h203FFFFC);
               end else if (kmode == 3) begin
                  chk("zero_word", w_data, 32'h0);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
      #1;
      chk("reset_outputs", {w_valid, w_last, w_idx, w_data}, 40'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {blk_ready, w_valid}, 2'b10);

      kmode = 1; rdy_rand = 1'b0;
      send_block(ABC_BLK);  wait_drain();
      kmode = 2;
      send_block(ONES_BLK); wait_drain();
      kmode = 1; rdy_rand = 1'b1;
      send_block(ABC_BLK);  wait_drain();
      kmode = 0;
      for (int i = 0; i < 3; i++) begin send_block(rnd_blk()); wait_drain(); end
      send_b2b(rnd_blk(), rnd_blk()); wait_drain();

      // Reset in the middle of a block.
      send_block(rnd_blk());
      n = 0;
      while (!(w_valid && w_idx == 6'd20) && n < 1000) begin @(negedge clk); n++; end
      chk("reach_t20", 64'(n < 1000), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("mid_reset_outputs", {w_valid, w_last, w_idx, w_data}, 40'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_mid_reset", {blk_ready, w_valid}, 2'b10);
      repeat (5) @(negedge clk);
      kmode = 3;
      send_block('0); wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
